uart_mmio_bridge: RTL and testbench

//  Memory-mapped console responder on the core's RAM-style port (ren/raddr/rdata, wen/waddr/wdata/wmask).

---
 rtl/uart_mmio_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_mmio_bridge.sv | 180 ++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared register map, bit positions and RX poll state encoding for the UART MMIO bridge.
package uart_mmio_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_RX_VALID = 2;
    localparam int unsigned STAT_TX_OVF   = 3;
    localparam int unsigned STAT_TX_COUNT = 8;

    localparam int unsigned CTRL_TX_EN     = 0;
    localparam int unsigned CTRL_RX_EN     = 1;
    localparam int unsigned CTRL_RX_IRQ_EN = 2;
    localparam logic [2:0]  CTRL_RESET     = 3'b011;

    localparam logic [7:0] NO_CHAR = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StPoll,
        StHold
    } rxState_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Power-of-two FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pushOk;
    logic             popOk;

    always_comb begin
        count  = wrPtr - rdPtr;
        full   = (count == (AW + 1)'(DEPTH));
        empty  = (count == '0);
        popOk  = pop & ~empty;
        pushOk = push & (~full | popOk);
        head   = mem[rdPtr[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + (AW + 1)'(1);
            if (popOk)  rdPtr <= rdPtr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (pushOk) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped console: TXDATA stores queue into a FIFO drained to io_uart_out_*,
// and an RX poller periodically samples io_uart_in_ch into a one-byte holding register.
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h1000_0000,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned TX_GAP    = 0,
    parameter int unsigned RX_POLL   = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ren,
    input  logic [63:0] raddr,
    output logic [63:0] rdata,
    input  logic        wen,
    input  logic [63:0] waddr,
    input  logic [63:0] wdata,
    input  logic [63:0] wmask,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch,
    output logic        irq
);

    localparam int unsigned CW     = $clog2(TX_DEPTH) + 1;
    localparam int unsigned GAP_W  = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
    localparam int unsigned POLL_W = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;
    localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(RX_POLL - 1);

    logic          rHit, wHit;
    logic [1:0]    rOff, wOff;
    logic          wrTx, wrStatus, wrCtrl, rdRx;
    logic [2:0]    ctrl;
    logic          txOvf;
    logic [GAP_W-1:0] gapCnt;
    logic          txPop, txFull, txEmpty;
    logic [CW-1:0] txCount;
    logic [7:0]    txHead;
    logic [63:0]   statusWord, readData;

    rxState_e      rxState, rxNext;
    logic [POLL_W-1:0] pollCnt, pollCntNext;
    logic [7:0]    rxByte, rxByteNext;
    logic          rxValid, rxPop;

    logic unusedBits;
    assign unusedBits = ^{raddr[2:0], waddr[2:0], wdata[63:8], wmask[63:1]};

    always_comb begin
        rHit     = (raddr[63:5] == BASE_ADDR[63:5]);
        wHit     = (waddr[63:5] == BASE_ADDR[63:5]);
        rOff     = raddr[4:3];
        wOff     = waddr[4:3];
        wrTx     = wen & wHit & (wOff == OFF_TXDATA) & wmask[0];
        wrStatus = wen & wHit & (wOff == OFF_STATUS) & wmask[0];
        wrCtrl   = wen & wHit & (wOff == OFF_CTRL) & wmask[0];
        rdRx     = ren & rHit & (rOff == OFF_RXDATA);
        txPop    = ctrl[CTRL_TX_EN] & ~txEmpty & (gapCnt == '0);
        rxPop    = rdRx & rxValid;
    end

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_txFifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (wrTx),
        .pushData (wdata[7:0]),
        .pop      (txPop),
        .full     (txFull),
        .empty    (txEmpty),
        .count    (txCount),
        .head     (txHead)
    );

    always_comb begin
        statusWord                       = '0;
        statusWord[STAT_TX_FULL]         = txFull;
        statusWord[STAT_TX_EMPTY]        = txEmpty;
        statusWord[STAT_RX_VALID]        = rxValid;
        statusWord[STAT_TX_OVF]          = txOvf;
        statusWord[STAT_TX_COUNT +: 8]   = 8'(txCount);
        readData = '0;
        if (rHit) begin
            unique case (rOff)
                OFF_TXDATA: readData = '0;
                OFF_RXDATA: readData = rxValid ? {55'b0, 1'b1, rxByte} : '0;
                OFF_STATUS: readData = statusWord;
                OFF_CTRL:   readData = {61'b0, ctrl};
                default:    readData = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata             <= '0;
            ctrl              <= CTRL_RESET;
            txOvf             <= 1'b0;
            io_uart_out_valid <= 1'b0;
            io_uart_out_ch    <= '0;
            gapCnt            <= '0;
        end else begin
            if (ren) rdata <= readData;
            if (wrCtrl) ctrl <= wdata[2:0];
            // A dropped push on the same edge as a clear leaves the flag set.
            if (wrTx & txFull & ~txPop) begin
                txOvf <= 1'b1;
            end else if (wrStatus & wdata[STAT_TX_OVF]) begin
                txOvf <= 1'b0;
            end
            io_uart_out_valid <= txPop;
            if (txPop) io_uart_out_ch <= txHead;
            if (txPop) begin
                gapCnt <= GAP_W'(TX_GAP);
            end else if (gapCnt != '0) begin
                gapCnt <= gapCnt - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxState <= StIdle;
            pollCnt <= '0;
            rxByte  <= '0;
        end else begin
            rxState <= rxNext;
            pollCnt <= pollCntNext;
            rxByte  <= rxByteNext;
        end
    end

    // A held byte stays in HOLD even with rx_en low, so polling never overwrites it.
    always_comb begin
        rxNext      = rxState;
        pollCntNext = pollCnt;
        rxByteNext  = rxByte;
        case (rxState)
            StIdle: begin
                if (!ctrl[CTRL_RX_EN]) begin
                    pollCntNext = POLL_RELOAD;
                end else if (pollCnt == '0) begin
                    rxNext = StPoll;
                end else begin
                    pollCntNext = pollCnt - POLL_W'(1);
                end
            end
            StPoll: begin
                if (ctrl[CTRL_RX_EN] && (io_uart_in_ch != NO_CHAR)) begin
                    rxNext     = StHold;
                    rxByteNext = io_uart_in_ch;
                end else begin
                    rxNext      = StIdle;
                    pollCntNext = POLL_RELOAD;
                end
            end
            StHold: begin
                if (rxPop) begin
                    rxNext      = StIdle;
                    pollCntNext = POLL_RELOAD;
                end
            end
            default: begin
                rxNext      = StIdle;
                pollCntNext = POLL_RELOAD;
            end
        endcase
    end

    always_comb begin
        io_uart_in_valid = (rxState == StPoll);
        rxValid          = (rxState == StHold);
        irq              = rxValid & ctrl[CTRL_RX_IRQ_EN];
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Randomized self-checking bench for uart_mmio_bridge against a queue-based console model.
module tb_uart_mmio_bridge;
    import uart_mmio_pkg::*;

    localparam logic [63:0] BASE    = 64'h1000_0000;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned RX_POLL = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ren = 1'b0, wen = 1'b0;
    logic [63:0] raddr = '0, waddr = '0, wdata = '0, wmask = '0;
    logic [63:0] rdata;
    logic        io_uart_out_valid, io_uart_in_valid, irq;
    logic [7:0]  io_uart_out_ch;
    logic [7:0]  io_uart_in_ch = 8'hFF;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    typedef struct {
        int         c;
        logic [7:0] ch;
    } txEv_t;

    txEv_t      gotTx[$];
    int         pollQ[$];
    logic [7:0] expTx[$];

    uart_mmio_bridge #(
        .BASE_ADDR (BASE),
        .TX_DEPTH  (DEPTH),
        .TX_GAP    (0),
        .RX_POLL   (RX_POLL)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ren               (ren),
        .raddr             (raddr),
        .rdata             (rdata),
        .wen               (wen),
        .waddr             (waddr),
        .wdata             (wdata),
        .wmask             (wmask),
        .io_uart_out_valid (io_uart_out_valid),
        .io_uart_out_ch    (io_uart_out_ch),
        .io_uart_in_valid  (io_uart_in_valid),
        .io_uart_in_ch     (io_uart_in_ch),
        .irq               (irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    txEv_t ev;
    always @(negedge clock) begin
        if (reset_n) begin
            if (io_uart_out_valid) begin
                ev.c  = cyc;
                ev.ch = io_uart_out_ch;
                gotTx.push_back(ev);
            end
            if (io_uart_in_valid) pollQ.push_back(cyc);
        end
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic writeAddr(input logic [63:0] addr, input logic [63:0] data,
                             input logic [63:0] mask);
        waddr = addr;
        wdata = data;
        wmask = mask;
        wen   = 1'b1;
        step();
        wen   = 1'b0;
    endtask

    task automatic regWrite(input logic [1:0] off, input logic [63:0] data);
        writeAddr(BASE + 64'(off) * 8 + 64'($urandom_range(0, 7)), data, '1);
    endtask

    task automatic readAddr(input logic [63:0] addr, output logic [63:0] d);
        raddr = addr;
        ren   = 1'b1;
        step();
        ren   = 1'b0;
        d     = rdata;
    endtask

    task automatic checkRead(input string tag, input logic [1:0] off, input logic [63:0] exp);
        logic [63:0] d;
        readAddr(BASE + 64'(off) * 8 + 64'($urandom_range(0, 7)), d);
        checkEq(tag, d, exp);
    endtask

    task automatic waitTx(input int n, input int budget, input string tag);
        while (gotTx.size() < n && budget > 0) begin
            step();
            budget--;
        end
        checkEq(tag, 64'(gotTx.size()), 64'(n));
    endtask

    task automatic waitPoll(input int n, input int budget, input string tag);
        while (pollQ.size() < n && budget > 0) begin
            step();
            budget--;
        end
        checkEq(tag, 64'(pollQ.size()), 64'(n));
    endtask

    function automatic logic [63:0] statusOf(input int cnt, input bit ovf, input bit rxv);
        return (64'(cnt) << 8) | (ovf ? 64'h8 : 64'h0) | (rxv ? 64'h4 : 64'h0)
             | ((cnt == 0) ? 64'h2 : 64'h0) | ((cnt == int'(DEPTH)) ? 64'h1 : 64'h0);
    endfunction

    task automatic checkDrain(input string tag);
        for (int i = 0; i < expTx.size() && i < gotTx.size(); i++) begin
            checkEq({tag, "_ch"}, 64'(gotTx[i].ch), 64'(expTx[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  b;
        int          n;
        bit          ovf;

        // Reset state
        #2 reset_n = 1'b0;
        step(2);
        checkEq("rst_rdata", rdata, 64'h0);
        checkEq("rst_out_valid", 64'(io_uart_out_valid), 64'h0);
        checkEq("rst_out_ch", 64'(io_uart_out_ch), 64'h0);
        checkEq("rst_in_valid", 64'(io_uart_in_valid), 64'h0);
        checkEq("rst_irq", 64'(irq), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        checkRead("status_reset", OFF_STATUS, 64'h2);
        checkRead("ctrl_reset", OFF_CTRL, 64'h3);
        checkRead("txdata_read", OFF_TXDATA, 64'h0);
        checkRead("rxdata_empty", OFF_RXDATA, 64'h0);
        readAddr(BASE + 64'h30, d);
        checkEq("miss_read", d, 64'h0);

        // Two back-to-back stores drain on consecutive cycles
        gotTx.delete();
        regWrite(OFF_TXDATA, 64'h41);
        regWrite(OFF_TXDATA, 64'h42);
        waitTx(2, 10, "ab_count");
        if (gotTx.size() >= 2) begin
            checkEq("ab_ch0", 64'(gotTx[0].ch), 64'h41);
            checkEq("ab_ch1", 64'(gotTx[1].ch), 64'h42);
            checkEq("ab_gap", 64'(gotTx[1].c - gotTx[0].c), 64'h1);
        end
        step(5);
        checkEq("ab_total", 64'(gotTx.size()), 64'h2);

        // Overflow with draining frozen, then W1C and drain
        regWrite(OFF_CTRL, 64'h2);
        expTx.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i < int'(DEPTH)) expTx.push_back(b);
            regWrite(OFF_TXDATA, {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FF00 | 64'(b));
        end
        checkRead("ovf_status", OFF_STATUS, 64'h1009);
        regWrite(OFF_STATUS, 64'h8);
        checkRead("ovf_cleared", OFF_STATUS, 64'h1001);
        gotTx.delete();
        regWrite(OFF_CTRL, 64'h3);
        waitTx(DEPTH, 40, "ovf_drain_count");
        checkDrain("ovf_drain");
        checkRead("ovf_after", OFF_STATUS, 64'h2);

        // Push into a full FIFO on the same edge as the first pop
        regWrite(OFF_CTRL, 64'h2);
        expTx.delete();
        for (int i = 0; i < int'(DEPTH); i++) begin
            b = 8'($urandom);
            expTx.push_back(b);
            regWrite(OFF_TXDATA, 64'(b));
        end
        b = 8'($urandom);
        expTx.push_back(b);
        gotTx.delete();
        regWrite(OFF_CTRL, 64'h3);
        regWrite(OFF_TXDATA, 64'(b));
        waitTx(DEPTH + 1, 40, "fullpop_count");
        checkDrain("fullpop");
        checkRead("fullpop_status", OFF_STATUS, 64'h2);

        // Randomized bursts: valid pushes, masked-off lane 0, and out-of-window stores
        for (int r = 0; r < 4; r++) begin
            regWrite(OFF_CTRL, 64'h2);
            expTx.delete();
            ovf = 1'b0;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                case ($urandom_range(0, 5))
                    0: writeAddr(BASE + 64'($urandom_range(0, 7)), 64'(b),
                                 64'hFFFF_FFFF_FFFF_FF00);
                    1: writeAddr(BASE + 64'h20 * 64'($urandom_range(1, 4)), 64'(b), '1);
                    default: begin
                        if (expTx.size() < int'(DEPTH)) expTx.push_back(b);
                        else ovf = 1'b1;
                        regWrite(OFF_TXDATA, 64'(b));
                    end
                endcase
            end
            checkRead("rnd_status", OFF_STATUS, statusOf(expTx.size(), ovf, 1'b0));
            gotTx.delete();
            regWrite(OFF_CTRL, 64'h3);
            waitTx(expTx.size(), 60, "rnd_drain_count");
            checkDrain("rnd_drain");
            regWrite(OFF_STATUS, 64'h8);
            checkRead("rnd_status_end", OFF_STATUS, 64'h2);
        end

        // RX: idle poll period, capture, irq, pop, repoll timing
        pollQ.delete();
        waitPoll(2, 4 * RX_POLL, "poll_seen");
        if (pollQ.size() >= 2) checkEq("poll_period", 64'(pollQ[1] - pollQ[0]), 64'(RX_POLL + 1));
        io_uart_in_ch = 8'h5A;
        waitPoll(3, 4 * RX_POLL, "poll_capture");
        io_uart_in_ch = 8'hFF;
        n = pollQ.size();
        step(3 * RX_POLL);
        checkEq("hold_no_poll", 64'(pollQ.size()), 64'(n));
        checkRead("rx_status", OFF_STATUS, 64'h6);
        checkEq("irq_disabled", 64'(irq), 64'h0);
        regWrite(OFF_CTRL, 64'h7);
        checkEq("irq_enabled", 64'(irq), 64'h1);
        checkRead("rxdata_pop", OFF_RXDATA, 64'h15A);
        n = cyc;
        checkEq("irq_after_pop", 64'(irq), 64'h0);
        checkRead("rxdata_again", OFF_RXDATA, 64'h0);
        waitPoll(4, 4 * RX_POLL, "repoll_seen");
        if (pollQ.size() >= 4) checkEq("repoll_delay", 64'(pollQ[3] - n), 64'(RX_POLL));

        // rx_en low stops polling
        regWrite(OFF_CTRL, 64'h5);
        step(2);
        n = pollQ.size();
        step(4 * RX_POLL);
        checkEq("rx_disabled", 64'(pollQ.size()), 64'(n));

        // Random RX bytes
        regWrite(OFF_CTRL, 64'h3);
        for (int r = 0; r < 4; r++) begin
            b = 8'($urandom_range(0, 254));
            io_uart_in_ch = b;
            n = pollQ.size();
            waitPoll(n + 1, 4 * RX_POLL, "rnd_poll");
            io_uart_in_ch = 8'hFF;
            checkRead("rnd_rx_status", OFF_STATUS, 64'h6);
            checkRead("rnd_rxdata", OFF_RXDATA, {55'b0, 1'b1, b});
        end

        // Asynchronous reset in the middle of a drain
        regWrite(OFF_CTRL, 64'h2);
        for (int i = 0; i < 8; i++) regWrite(OFF_TXDATA, 64'($urandom));
        gotTx.delete();
        regWrite(OFF_CTRL, 64'h3);
        waitTx(2, 10, "mid_drain_started");
        checkEq("mid_drain_active", 64'(io_uart_out_valid), 64'h1);
        reset_n = 1'b0;
        #1;
        checkEq("async_rst_out_valid", 64'(io_uart_out_valid), 64'h0);
        checkEq("async_rst_rdata", rdata, 64'h0);
        #20;
        @(negedge clock);
        reset_n = 1'b1;
        gotTx.delete();
        step(20);
        checkEq("after_rst_no_tx", 64'(gotTx.size()), 64'h0);
        checkRead("after_rst_status", OFF_STATUS, 64'h2);
        checkRead("after_rst_ctrl", OFF_CTRL, 64'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
